// File: rtl/hbus_ioddr_pkg.sv
// Shared types and helpers for the HyperBus DDR pad block.
// Holds the DDR phase encoding, default geometry and phase decode.
package hbus_ioddr_pkg;

  typedef enum logic {
    PhaseLow  = 1'b0,
    PhaseHigh = 1'b1
  } phase_e;

  localparam int DefaultWidth = 8;

  // Toggles differ between a rising edge and the following falling edge.
  function automatic phase_e phaseOf(input logic posTgl, input logic negTgl);
    return phase_e'(posTgl ^ negTgl);
  endfunction

endpackage

// File: rtl/hbus_ioddr_bit.sv
// Single-pin DDR in/out cell: serialises a hi/lo pair onto one pad
// and deserialises both pad phases back into a hi/lo pair.
module hbus_ioddr_bit
  import hbus_ioddr_pkg::*;
#(
  parameter string TARGET = "GENERIC"
) (
  input  logic clk,
  input  logic rstn,
  input  logic hi_i,
  input  logic lo_i,
  input  logic oe_i,
  output logic hi_o,
  output logic lo_o,
  inout  wire  pad
);

  logic fall_q;
  logic datHi_q;
  logic datLo_q;

  if (TARGET == "ALTERA") begin : g_altera
    logic hi_q;
    logic lo_q;
    logic loNeg_q;
    logic oe_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hi_q <= 1'b0;
        lo_q <= 1'b0;
        oe_q <= 1'b0;
      end else begin
        hi_q <= hi_i;
        lo_q <= lo_i;
        oe_q <= oe_i;
      end
    end

    always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) begin
        loNeg_q <= 1'b0;
      end else begin
        loNeg_q <= lo_q;
      end
    end

    // Same register arrangement as the DDIO IOE cell, whose output mux is clock-selected in silicon.
    assign pad = oe_q ? (clk ? hi_q : loNeg_q) : 1'bz;
  end else begin : g_generic
    logic   hi_q;
    logic   lo_q;
    logic   loNeg_q;
    logic   oe_q;
    logic   posTgl_q;
    logic   negTgl_q;
    phase_e phase;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        hi_q     <= 1'b0;
        lo_q     <= 1'b0;
        oe_q     <= 1'b0;
        posTgl_q <= 1'b0;
      end else begin
        hi_q     <= hi_i;
        lo_q     <= lo_i;
        oe_q     <= oe_i;
        posTgl_q <= ~posTgl_q;
      end
    end

    always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) begin
        loNeg_q  <= 1'b0;
        negTgl_q <= 1'b0;
      end else begin
        loNeg_q  <= lo_q;
        negTgl_q <= posTgl_q;
      end
    end

    // Registered toggles pick the phase, so clk never reaches the data mux.
    assign phase = phaseOf(posTgl_q, negTgl_q);
    assign pad   = oe_q ? ((phase == PhaseHigh) ? hi_q : loNeg_q) : 1'bz;
  end

  // High-phase value is complete at the falling edge; low-phase value at the next rising edge.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= pad;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      datHi_q <= 1'b0;
      datLo_q <= 1'b0;
    end else begin
      datHi_q <= fall_q;
      datLo_q <= pad;
    end
  end

  assign hi_o = datHi_q;
  assign lo_o = datLo_q;

endmodule

// File: rtl/hbus_ioddr.sv
// HyperBus DDR pad block: WIDTH bidirectional pins, 2*WIDTH-bit words per clk.
// Upper word half travels in the high phase, lower half in the low phase.
module hbus_ioddr
  import hbus_ioddr_pkg::*;
#(
  parameter string TARGET = "GENERIC",
  parameter int    WIDTH  = DefaultWidth
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2*WIDTH-1:0] dat_i,
  output logic [2*WIDTH-1:0] dat_o,
  input  logic               oe,
  inout  wire  [WIDTH-1:0]   dq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    hbus_ioddr_bit #(
      .TARGET(TARGET)
    ) u_bit (
      .clk (clk),
      .rstn(rstn),
      .hi_i(dat_i[WIDTH+i]),
      .lo_i(dat_i[i]),
      .oe_i(oe),
      .hi_o(dat_o[WIDTH+i]),
      .lo_o(dat_o[i]),
      .pad (dq[i])
    );
  end

endmodule

// File: tb/tb_hbus_ioddr.sv
// Randomised scoreboard bench for hbus_ioddr: an 8-pin DQ lane and a 1-pin RWDS lane.
// Pins left floating read as all ones through pull-ups, which is how tri-state is observed.
module tb_hbus_ioddr;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rstn;
  logic [15:0] datI8;
  logic [15:0] datO8;
  logic        oe8;
  wire  [7:0]  dq8;
  logic [7:0]  tbDrv8;
  logic        tbEn8;
  logic [1:0]  datI1;
  logic [1:0]  datO1;
  logic        oe1;
  wire         dq1;
  logic        tbDrv1;
  logic        tbEn1;

  assign dq8 = tbEn8 ? tbDrv8 : 8'hzz;
  assign dq1 = tbEn1 ? tbDrv1 : 1'bz;
  pullup pu8 (dq8);
  pullup pu1 (dq1);

  hbus_ioddr #(.TARGET("GENERIC"), .WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .dat_i(datI8),
    .dat_o(datO8),
    .oe   (oe8),
    .dq   (dq8)
  );

  hbus_ioddr #(.TARGET("GENERIC"), .WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .dat_i(datI1),
    .dat_o(datO1),
    .oe   (oe1),
    .dq   (dq1)
  );

  typedef struct {
    int          cyc;
    bit          lane;
    logic [15:0] exp;
  } exp_t;

  typedef struct {
    bit          dut;
    bit          tb;
    logic [15:0] word;
  } plan_t;

  exp_t  hiQ[$];
  exp_t  loQ[$];
  exp_t  datQ[$];
  plan_t cur8, cur1, nxt8, nxt1;
  int    vecCount  = 0;
  int    missCount = 0;
  int    cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pins during a cycle are whoever drives them, else the pull-up; dat_o returns them one cycle later.
  task automatic planNext(input int m8, input logic [15:0] w8, input int m1, input logic [1:0] w1);
    int k;
    logic [7:0] ph, pl;
    logic bh, bl;
    k = cyc + 1;
    if (m8 == 3) m8 = $urandom_range(0, 2);
    if (m1 == 3) m1 = $urandom_range(0, 2);
    nxt8 = '{dut: (m8 == 1), tb: (m8 == 2), word: w8};
    nxt1 = '{dut: (m1 == 1), tb: (m1 == 2), word: {14'b0, w1}};
    datI8 = w8;
    oe8   = nxt8.dut;
    datI1 = w1;
    oe1   = nxt1.dut;
    ph = (nxt8.dut || nxt8.tb) ? w8[15:8] : 8'hFF;
    pl = (nxt8.dut || nxt8.tb) ? w8[7:0]  : 8'hFF;
    bh = (nxt1.dut || nxt1.tb) ? w1[1] : 1'b1;
    bl = (nxt1.dut || nxt1.tb) ? w1[0] : 1'b1;
    hiQ.push_back('{k, 1'b0, {8'h00, ph}});
    loQ.push_back('{k, 1'b0, {8'h00, pl}});
    datQ.push_back('{k + 1, 1'b0, {ph, pl}});
    hiQ.push_back('{k, 1'b1, {15'b0, bh}});
    loQ.push_back('{k, 1'b1, {15'b0, bl}});
    datQ.push_back('{k + 1, 1'b1, {14'b0, bh, bl}});
  endtask

  // Entered and left just after a rising edge; plans the following cycle.
  task automatic applyStimulus(input int m8, input logic [15:0] w8, input int m1, input logic [1:0] w1);
    tbEn8  = cur8.tb;
    tbDrv8 = cur8.word[15:8];
    tbEn1  = cur1.tb;
    tbDrv1 = cur1.word[1];
    planNext(m8, w8, m1, w1);
    @(negedge clk);
    #1;
    tbDrv8 = cur8.word[7:0];
    tbDrv1 = cur1.word[0];
    @(posedge clk);
    #1;
    cur8 = nxt8;
    cur1 = nxt1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (datQ.size() > 0 && datQ[0].cyc == cyc) begin
        e = datQ.pop_front();
        checkOutput($sformatf("dat_o lane%0d cyc%0d", e.lane, e.cyc),
                    e.lane ? {14'b0, datO1} : datO8, e.exp);
      end
      while (hiQ.size() > 0 && hiQ[0].cyc == cyc) begin
        e = hiQ.pop_front();
        checkOutput($sformatf("dq high phase lane%0d cyc%0d", e.lane, e.cyc),
                    e.lane ? {15'b0, dq1} : {8'h00, dq8}, e.exp);
      end
      @(negedge clk);
      #3;
      while (loQ.size() > 0 && loQ[0].cyc == cyc) begin
        e = loQ.pop_front();
        checkOutput($sformatf("dq low phase lane%0d cyc%0d", e.lane, e.cyc),
                    e.lane ? {15'b0, dq1} : {8'h00, dq8}, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] bench timed out");
  end

  initial begin : driver
    int leftover;
    rstn   = 1'b0;
    oe8    = 1'b1;
    datI8  = 16'hA55A;
    oe1    = 1'b1;
    datI1  = 2'b10;
    tbEn8  = 1'b0;
    tbEn1  = 1'b0;
    tbDrv8 = 8'h00;
    tbDrv1 = 1'b0;
    cur8   = '{dut: 1'b0, tb: 1'b0, word: 16'h0};
    cur1   = cur8;

    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset dq8 floating", {8'h00, dq8}, 16'h00FF);
    checkOutput("reset dat_o8", datO8, 16'h0000);
    checkOutput("reset dq1 floating", {15'b0, dq1}, 16'h0001);
    checkOutput("reset dat_o1", {14'b0, datO1}, 16'h0000);

    @(negedge clk);
    #1;
    rstn = 1'b1;
    #1;
    checkOutput("release dq8 floating", {8'h00, dq8}, 16'h00FF);
    checkOutput("release dq1 floating", {15'b0, dq1}, 16'h0001);
    planNext(1, 16'hA55A, 1, 2'b10);
    @(posedge clk);
    #1;
    cur8 = nxt8;
    cur1 = nxt1;

    applyStimulus(1, 16'h1234, 2, 2'b10);
    applyStimulus(0, 16'h0000, 2, 2'b11);
    applyStimulus(2, 16'hC33C, 2, 2'b00);
    applyStimulus(1, 16'h5A0F, 1, 2'b10);
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i % 2 == 0) ? 2 : 1, 16'($urandom), (i % 2 == 0) ? 1 : 2, 2'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      applyStimulus(3, 16'($urandom), 3, 2'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'($urandom), 1, 2'($urandom));
    end

    #5;
    rstn = 1'b0;
    hiQ.delete();
    loQ.delete();
    datQ.delete();
    tbEn8 = 1'b0;
    tbEn1 = 1'b0;
    #1;
    checkOutput("midburst reset dq8 floating", {8'h00, dq8}, 16'h00FF);
    checkOutput("midburst reset dat_o8", datO8, 16'h0000);
    checkOutput("midburst reset dq1 floating", {15'b0, dq1}, 16'h0001);
    checkOutput("midburst reset dat_o1", {14'b0, datO1}, 16'h0000);
    #1;
    rstn = 1'b1;
    cur8 = '{dut: 1'b0, tb: 1'b0, word: 16'h0};
    cur1 = cur8;
    planNext(1, 16'h9E61, 1, 2'b01);
    @(posedge clk);
    #1;
    cur8 = nxt8;
    cur1 = nxt1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3, 16'($urandom), 3, 2'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 16'($urandom), 0, 2'($urandom));
    end
    repeat (3) @(posedge clk);
    #5;

    leftover = hiQ.size() + loQ.size() + datQ.size();
    if (leftover != 0) begin
      vecCount  += leftover;
      missCount += leftover;
      $display("[TB] FAIL scoreboard drain: got %0d unchecked entries, expected 0", leftover);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
